// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests a word from instruction memory, holds it
// for decode, then computes the next PC from the retiring instruction's controls.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        start,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        fetch_err,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state, w_next;
  logic        r_armed;
  logic [31:0] r_pc, r_inst, r_inst_pc;
  logic [7:0]  r_wait;
  logic [15:0] r_count;

  logic        w_hs;
  logic [31:0] w_seq, w_brt, w_jmp, w_npc;

  assign w_hs  = (r_state == HOLD) && inst_ready;
  assign w_seq = r_inst_pc + 32'd4;
  assign w_brt = w_seq + {{16{r_inst[15]}}, r_inst[15:0]};
  assign w_jmp = {r_inst_pc[31:26], r_inst[25:0]};

  always_comb begin
    w_npc = w_seq;
    if (jump)               w_npc = w_jmp;
    else if (branch && zero) w_npc = w_brt;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      // r_armed gives IDLE one full clock after reset release
      IDLE: if (r_armed) w_next = REQ;
      REQ: begin
        if (mem_ack)                  w_next = HOLD;
        else if (r_wait == WAIT_LAST) w_next = ERR;
      end
      HOLD: if (w_hs) w_next = REQ;
      ERR:  w_next = ERR;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      r_state   <= IDLE;
      r_armed   <= 1'b0;
      r_pc      <= RESET_PC;
      r_inst    <= 32'd0;
      r_inst_pc <= 32'd0;
      r_wait    <= 8'd0;
      r_count   <= 16'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: r_armed <= 1'b1;
        REQ: begin
          if (mem_ack) begin
            r_inst    <= mem_rdata;
            r_inst_pc <= r_pc;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        HOLD: begin
          if (w_hs) begin
            r_pc    <= w_npc;
            r_count <= r_count + 16'd1;
            r_wait  <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req     = (r_state == REQ);
  assign mem_addr    = r_pc;
  assign inst_valid  = (r_state == HOLD);
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign fetch_err   = (r_state == ERR);
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: table-driven fetch chain, randomized fetches against a
// PC model, plus reset, wrap, jump and timeout sequences on parameterized instances.
module tb_fetch_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // instance A: default parameters
  logic        a_start, a_ack, a_ready, a_br, a_zr, a_jp;
  logic [31:0] a_rdata;
  logic        a_req, a_vld, a_err;
  logic [31:0] a_addr, a_inst, a_ipc;
  logic [15:0] a_cnt;

  // instances B and C share inputs; both use MAX_WAIT=4
  logic        b_start, b_ack, b_ready, b_br, b_zr, b_jp;
  logic [31:0] b_rdata;
  logic        b_req, b_vld, b_err, c_req, c_vld, c_err;
  logic [31:0] b_addr, b_inst, b_ipc, c_addr, c_inst, c_ipc;
  logic [15:0] b_cnt, c_cnt;

  fetch_sequencer u_a (
    .clock(clock), .start(a_start), .mem_req(a_req), .mem_addr(a_addr),
    .mem_ack(a_ack), .mem_rdata(a_rdata), .inst_valid(a_vld), .inst_ready(a_ready),
    .inst(a_inst), .inst_pc(a_ipc), .branch(a_br), .zero(a_zr), .jump(a_jp),
    .fetch_err(a_err), .fetch_count(a_cnt));

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .MAX_WAIT(4)) u_b (
    .clock(clock), .start(b_start), .mem_req(b_req), .mem_addr(b_addr),
    .mem_ack(b_ack), .mem_rdata(b_rdata), .inst_valid(b_vld), .inst_ready(b_ready),
    .inst(b_inst), .inst_pc(b_ipc), .branch(b_br), .zero(b_zr), .jump(b_jp),
    .fetch_err(b_err), .fetch_count(b_cnt));

  fetch_sequencer #(.RESET_PC(32'hF000_0010), .MAX_WAIT(4)) u_c (
    .clock(clock), .start(b_start), .mem_req(c_req), .mem_addr(c_addr),
    .mem_ack(b_ack), .mem_rdata(b_rdata), .inst_valid(c_vld), .inst_ready(b_ready),
    .inst(c_inst), .inst_pc(c_ipc), .branch(b_br), .zero(b_zr), .jump(b_jp),
    .fetch_err(c_err), .fetch_count(c_cnt));

  int tests = 0;
  int fails = 0;
  logic [31:0] m_pc;
  int          m_cnt;

  typedef struct {
    logic [31:0] rd;
    logic        br, zr, jp;
    int          ad, rdl;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input logic br, input logic zr, input logic jp);
    int off;
    if (jp) return (pc & 32'hFC00_0000) | (w & 32'h03FF_FFFF);
    off = int'($signed(w[15:0]));
    if (br && zr) return pc + 32'd4 + 32'(off);
    return pc + 32'd4;
  endfunction

  // one fetch on instance A, entered and left at a negedge while in REQ
  task automatic fetch(input logic [31:0] rd, input logic br, input logic zr, input logic jp,
                       input int ad, input int rdl);
    logic [31:0] pc0;
    pc0 = m_pc;
    chk("req_addr", a_addr, m_pc);
    chk("req_on", 32'(a_req), 32'd1);
    chk("req_novld", 32'(a_vld), 32'd0);
    for (int i = 0; i < ad; i++) begin
      a_ack = 1'b0; a_rdata = $urandom; a_ready = 1'($urandom);
      a_br = 1'($urandom); a_zr = 1'($urandom); a_jp = 1'($urandom);
      @(negedge clock);
      chk("wait_req", 32'(a_req), 32'd1);
      chk("wait_err", 32'(a_err), 32'd0);
    end
    a_ack = 1'b1; a_rdata = rd; a_ready = 1'($urandom);
    @(negedge clock);
    a_ack = 1'b0; a_rdata = $urandom;
    chk("hold_vld", 32'(a_vld), 32'd1);
    chk("hold_noreq", 32'(a_req), 32'd0);
    chk("hold_inst", a_inst, rd);
    chk("hold_ipc", a_ipc, pc0);
    for (int i = 0; i < rdl; i++) begin
      a_ready = 1'b0; a_ack = 1'($urandom);
      a_br = 1'($urandom); a_zr = 1'($urandom); a_jp = 1'($urandom);
      @(negedge clock);
      chk("bp_vld", 32'(a_vld), 32'd1);
      chk("bp_inst", a_inst, rd);
      chk("bp_ipc", a_ipc, pc0);
      chk("bp_noreq", 32'(a_req), 32'd0);
      chk("bp_cnt", 32'(a_cnt), 32'(m_cnt % 65536));
    end
    a_ack = 1'b0; a_ready = 1'b1; a_br = br; a_zr = zr; a_jp = jp;
    @(negedge clock);
    a_ready = 1'b0; a_br = 1'($urandom); a_zr = 1'($urandom); a_jp = 1'($urandom);
    m_pc  = model_next(pc0, rd, br, zr, jp);
    m_cnt = m_cnt + 1;
    chk("next_addr", a_addr, m_pc);
    chk("next_cnt", 32'(a_cnt), 32'(m_cnt % 65536));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h1111_1111, 1'b0, 1'b0, 1'b0, 0,  0, 32'h0000_0004};
    tbl[1]  = '{32'h1111_1111, 1'b0, 1'b0, 1'b0, 0,  0, 32'h0000_0008};
    tbl[2]  = '{32'h1111_1111, 1'b0, 1'b0, 1'b0, 0,  0, 32'h0000_000C};
    tbl[3]  = '{32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 2,  1, 32'h0000_0010};
    tbl[4]  = '{32'h1000_000C, 1'b1, 1'b1, 1'b0, 1,  0, 32'h0000_0020};
    tbl[5]  = '{32'h1000_FFFC, 1'b1, 1'b1, 1'b0, 0,  5, 32'h0000_0020};
    tbl[6]  = '{32'h1000_FFFC, 1'b1, 1'b0, 1'b0, 14, 0, 32'h0000_0024};
    tbl[7]  = '{32'h0800_0100, 1'b1, 1'b1, 1'b1, 3,  2, 32'h0000_0100};
    tbl[8]  = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 0,  0, 32'h0000_0104};
    tbl[9]  = '{32'h0000_8000, 1'b1, 1'b1, 1'b0, 5,  3, 32'hFFFF_8108};
    tbl[10] = '{32'h0C00_0020, 1'b0, 1'b0, 1'b1, 0,  1, 32'hFC00_0020};
    tbl[11] = '{32'h0000_0FE0, 1'b1, 1'b1, 1'b0, 7,  0, 32'hFC00_1004};
    tbl[12] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0,  4, 32'hFC00_1008};

    a_start = 1'b0; a_ack = 1'b0; a_ready = 1'b0; a_br = 1'b0; a_zr = 1'b0; a_jp = 1'b0;
    a_rdata = 32'd0;
    b_start = 1'b0; b_ack = 1'b0; b_ready = 1'b0; b_br = 1'b0; b_zr = 1'b0; b_jp = 1'b0;
    b_rdata = 32'd0;
    m_pc = 32'd0; m_cnt = 0;

    repeat (2) @(negedge clock);
    chk("rst_req", 32'(a_req), 32'd0);
    chk("rst_addr", a_addr, 32'd0);
    chk("rst_vld", 32'(a_vld), 32'd0);
    chk("rst_inst", a_inst, 32'd0);
    chk("rst_ipc", a_ipc, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_addr_b", b_addr, 32'hFFFF_FFFC);
    chk("rst_addr_c", c_addr, 32'hF000_0010);

    a_start = 1'b1;
    @(negedge clock);
    chk("idle_noreq", 32'(a_req), 32'd0);
    chk("idle_novld", 32'(a_vld), 32'd0);
    @(negedge clock);
    chk("first_req", 32'(a_req), 32'd1);

    for (int i = 0; i < 13; i++) begin
      fetch(tbl[i].rd, tbl[i].br, tbl[i].zr, tbl[i].jp, tbl[i].ad, tbl[i].rdl);
      chk($sformatf("vec%0d_next", i), a_addr, tbl[i].exp);
    end

    for (int i = 0; i < 40; i++)
      fetch($urandom, 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 14)), int'($urandom_range(0, 3)));

    // reset while requesting
    a_start = 1'b0;
    #1;
    chk("rreq_req", 32'(a_req), 32'd0);
    chk("rreq_addr", a_addr, 32'd0);
    chk("rreq_cnt", 32'(a_cnt), 32'd0);
    @(negedge clock);
    a_start = 1'b1; m_pc = 32'd0; m_cnt = 0;
    @(negedge clock);
    chk("rreq_idle", 32'(a_req), 32'd0);
    @(negedge clock);
    chk("rreq_restart", 32'(a_req), 32'd1);

    // reset in HOLD with a handshake pending
    a_ack = 1'b1; a_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    a_ack = 1'b0;
    chk("rhold_vld", 32'(a_vld), 32'd1);
    a_ready = 1'b1; a_jp = 1'b1;
    a_start = 1'b0;
    #1;
    chk("rhold_vld0", 32'(a_vld), 32'd0);
    chk("rhold_inst", a_inst, 32'd0);
    chk("rhold_ipc", a_ipc, 32'd0);
    chk("rhold_addr", a_addr, 32'd0);
    chk("rhold_req", 32'(a_req), 32'd0);
    chk("rhold_err", 32'(a_err), 32'd0);
    @(negedge clock);
    a_ready = 1'b0; a_jp = 1'b0; a_start = 1'b1;
    repeat (2) @(negedge clock);
    chk("rhold_req1", 32'(a_req), 32'd1);
    chk("rhold_addr1", a_addr, 32'd0);
    chk("rhold_cnt", 32'(a_cnt), 32'd0);

    // B/C: jump keeps the upper PC bits
    b_start = 1'b1;
    @(negedge clock);
    chk("bc_idle", 32'(b_req), 32'd0);
    @(negedge clock);
    chk("bc_req", 32'(b_req), 32'd1);
    chk("b_addr0", b_addr, 32'hFFFF_FFFC);
    chk("c_addr0", c_addr, 32'hF000_0010);
    b_ack = 1'b1; b_rdata = 32'h0800_0100;
    @(negedge clock);
    b_ack = 1'b0;
    chk("c_hold", 32'(c_vld), 32'd1);
    chk("c_ipc", c_ipc, 32'hF000_0010);
    b_ready = 1'b1; b_jp = 1'b1; b_br = 1'b1; b_zr = 1'b1;
    @(negedge clock);
    b_ready = 1'b0; b_jp = 1'b0; b_br = 1'b0; b_zr = 1'b0;
    chk("c_jump", c_addr, 32'hF000_0100);
    chk("b_jump", b_addr, 32'hFC00_0100);

    // sequential wrap from 0xFFFFFFFC
    b_start = 1'b0;
    #1;
    chk("b_rst_addr", b_addr, 32'hFFFF_FFFC);
    @(negedge clock);
    b_start = 1'b1;
    repeat (2) @(negedge clock);
    b_ack = 1'b1; b_rdata = 32'h0000_0000;
    @(negedge clock);
    b_ack = 1'b0; b_ready = 1'b1;
    @(negedge clock);
    b_ready = 1'b0;
    chk("b_wrap", b_addr, 32'h0000_0000);
    chk("c_seq", c_addr, 32'hF000_0014);
    chk("b_cnt1", 32'(b_cnt), 32'd1);

    // timeout: four REQ cycles with no ack
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("to_req", 32'(b_req), 32'd1);
      chk("to_noerr", 32'(b_err), 32'd0);
    end
    @(negedge clock);
    chk("to_err", 32'(b_err), 32'd1);
    chk("to_noreq", 32'(b_req), 32'd0);
    chk("to_novld", 32'(b_vld), 32'd0);
    b_ack = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("err_sticky", 32'(b_err), 32'd1);
      chk("err_noreq", 32'(b_req), 32'd0);
      chk("err_novld", 32'(b_vld), 32'd0);
    end
    b_ack = 1'b0; b_ready = 1'b0;

    // ack in the last allowed REQ cycle wins over timeout
    b_start = 1'b0;
    #1;
    chk("err_clr", 32'(b_err), 32'd0);
    @(negedge clock);
    b_start = 1'b1;
    repeat (2) @(negedge clock);
    chk("late_req", 32'(b_req), 32'd1);
    repeat (3) @(negedge clock);
    b_ack = 1'b1; b_rdata = 32'hCAFE_0001;
    @(negedge clock);
    b_ack = 1'b0;
    chk("late_vld", 32'(b_vld), 32'd1);
    chk("late_noerr", 32'(b_err), 32'd0);
    chk("late_inst", b_inst, 32'hCAFE_0001);
    chk("late_vld_c", 32'(c_vld), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, the PC value loaded at reset.
REQ-002 Parameter MAX_WAIT, default 15, range 1..255, the maximum number of REQ cycles to wait for mem_ack before a fetch error.
REQ-003 Port clock, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port start, input, 1, reset: asynchronous and active-low.
REQ-005 Port mem_req, output, 1, instruction memory read request.
REQ-006 Port mem_addr, output, 32, memory byte address; equals the current PC.
REQ-007 Port mem_ack, input, 1, memory read complete; mem_rdata valid in the same cycle.
REQ-008 Port mem_rdata, input, 32, instruction word.
REQ-009 Port inst_valid, output, 1, the held instruction is available to decode.
REQ-010 Port inst_ready, input, 1, decode accepts the instruction this cycle.
REQ-011 Port inst, output, 32, held instruction word.
REQ-012 Port inst_pc, output, 32, address of the held instruction.
REQ-013 Port branch, input, 1, branch control for the held instruction; sampled only on handshake.
REQ-014 Port zero, input, 1, ALU zero flag for the held instruction; sampled only on handshake.
REQ-015 Port jump, input, 1, jump control for the held instruction; sampled only on handshake.
REQ-016 Port fetch_err, output, 1, sticky memory-timeout flag.
REQ-017 Port fetch_count, output, 16, number of retired instructions (handshakes).

Function
REQ-018 FSM states SHALL be IDLE, REQ, HOLD and ERR.
REQ-019 IDLE SHALL last one cycle after reset release, with all outputs deasserted, and then go to REQ.
REQ-020 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal pc; inst_valid SHALL be 0.
REQ-021 In REQ with mem_ack=1, the block SHALL capture inst<=mem_rdata and inst_pc<=pc, then go to HOLD; mem_req SHALL drop in the next cycle.
REQ-022 A wait counter SHALL clear on every entry to REQ and increment on each REQ cycle without mem_ack.
REQ-023 If MAX_WAIT consecutive REQ cycles pass without mem_ack, the FSM SHALL go to ERR.
REQ-024 An ack in the MAX_WAIT-th cycle SHALL be accepted; ack takes priority over timeout.
REQ-025 In HOLD, inst_valid SHALL be 1, and inst and inst_pc SHALL be stable until the handshake.
REQ-026 A handshake is inst_valid & inst_ready.
REQ-027 On handshake the FSM SHALL go to REQ and pc SHALL load the next PC.
REQ-028 On handshake, fetch_count SHALL increment, wrapping 16'hFFFF->0.
REQ-029 Next PC when jump=1 (priority over branch): {inst_pc[31:26], inst[25:0]}.
REQ-030 Next PC when jump=0 and branch&zero=1: inst_pc + 4 + sign-extend(inst[15:0]); the offset is not shifted.
REQ-031 Next PC otherwise: inst_pc + 4.
REQ-032 All PC arithmetic SHALL be 32-bit modulo 2^32; carries out are discarded.
REQ-033 branch, zero and jump SHALL be ignored when no handshake occurs.
REQ-034 inst_ready while not in HOLD SHALL be ignored.
REQ-035 mem_ack outside REQ SHALL be ignored.
REQ-036 Minimum fetch cycle with ack in the first REQ cycle and immediate ready SHALL be 2 clocks per instruction (REQ, HOLD).
REQ-037 ERR SHALL hold mem_req=0, inst_valid=0 and fetch_err=1 until reset.

Reset
REQ-038 While start=0, the block SHALL immediately force: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, fetch_count=0, wait counter=0.
REQ-039 Reset asserted mid-operation (in any state, including with mem_req=1 or during a pending handshake) SHALL abort the operation with no retirement and no PC update.
REQ-040 After start rises, the first mem_req SHALL assert on the second rising edge (IDLE, then REQ).

Verification
REQ-041 Sequential fetch: reset, mem_ack on the first REQ cycle, inst_ready=1, rdata 32'h11111111 -> mem_addr 0,4,8 on successive REQ cycles; fetch_count=3 after three handshakes.
REQ-042 Taken branch: inst 32'h1000FFFC at inst_pc 32'h20, with branch=1, zero=1 on handshake -> next mem_addr 32'h20. With zero=0 -> next mem_addr 32'h24.
REQ-043 Jump: inst_pc 32'hF0000010, inst 32'h08000100, jump=1 and branch=1 -> next mem_addr 32'hF0000100.
REQ-044 Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst_valid, inst and inst_pc stable; mem_req=0; fetch_count unchanged.
REQ-045 Timeout with MAX_WAIT=4: no ack -> fetch_err=1 after the 4th REQ cycle and mem_req=0 thereafter. Ack on the 4th cycle -> HOLD, fetch_err=0.
REQ-046 Wrap and reset: RESET_PC=32'hFFFFFFFC, sequential handshake -> next mem_addr 0. Reset asserted in HOLD -> all outputs at reset values within the same cycle, no clock needed.
